controlador_interrupciones: RTL and testbench

- Vectored interrupt controller that sequences the CPU's control unit (uc) into and out of interrupt service.
- Edge-detects and latches peripheral requests, applies a mask and a global enable, and picks one winner by fixed priority (index 0 highest).
- Raises irq to uc and supplies the service vector.
- uc pushes the PC on the subroutine stack (pilaSubR), loads the vector and pulses ack; on return it pulses reti.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/controlador_interrupciones_codificador.sv | 21 ++
 rtl/controlador_interrupciones.sv | 164 ++++++++++++++++
 tb/tb_controlador_interrupciones.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the interrupt controller: state encoding and
// default vector placement.
package cpu_pkg;

  typedef enum logic [1:0] {
    REPOSO      = 2'd0,
    SOLICITANDO = 2'd1,
    SERVICIO    = 2'd2
  } estado_t;

  localparam logic [9:0] VECTOR_BASE_DEF = 10'h3C0;
  localparam int         VECTOR_PASO_DEF = 4;

endpackage

// File: rtl/controlador_interrupciones_codificador.sv
// Fixed-priority encoder: reports the lowest set index of its input and
// whether any bit is set at all.
module codificador_prioridad #(
  parameter int N         = 4,
  parameter int ANCHO_IDX = 2
) (
  input  logic [N-1:0]         entrada,
  output logic [ANCHO_IDX-1:0] indice,
  output logic                 valido
);

  // Scanning from the top down lets the lowest set index overwrite the rest.
  always_comb begin
    indice = '0;
    valido = |entrada;
    for (int i = N - 1; i >= 0; i--) begin
      if (entrada[i]) indice = ANCHO_IDX'(i);
    end
  end

endmodule

// File: rtl/controlador_interrupciones.sv
// Vectored interrupt controller sequencing the control unit into and out of
// service. Define INT_ANIDADAS_EN to allow nested (preemptive) interrupts.
module controlador_interrupciones
  import cpu_pkg::*;
#(
  parameter int                      NUM_FUENTES  = 4,
  parameter int                      ANCHO_VECTOR = 10,
  parameter logic [ANCHO_VECTOR-1:0] VECTOR_BASE  = ANCHO_VECTOR'(VECTOR_BASE_DEF),
  parameter int                      VECTOR_PASO  = VECTOR_PASO_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_FUENTES-1:0]  peticion,
  input  logic                    mascara_we,
  input  logic [NUM_FUENTES-1:0]  mascara_dato,
  input  logic                    ei,
  input  logic                    di,
  input  logic                    ack,
  input  logic                    reti,
  output logic                    irq,
  output logic [ANCHO_VECTOR-1:0] vector,
  output logic [NUM_FUENTES-1:0]  pendientes,
  output logic [NUM_FUENTES-1:0]  en_servicio,
  output logic [1:0]              estado_dbg
);

  localparam int ANCHO_IDX = (NUM_FUENTES > 1) ? $clog2(NUM_FUENTES) : 1;

  // Handshake with uc: irq is a level held in SOLICITANDO; ack, reti, ei and
  // di are single-cycle pulses, and ack/reti only count in their own state.

  estado_t                 estado_q, estado_d;
  logic [NUM_FUENTES-1:0]  peticion_q, pend_q, serv_q, mascara_q;
  logic                    ge_q, ge_d;
  logic [ANCHO_IDX-1:0]    idx_q, idx_ret, ganador;
  logic [ANCHO_VECTOR-1:0] vector_q, vector_calc;
  logic [NUM_FUENTES-1:0]  flanco, elegible, sel_acepta, sel_ret;
  logic                    hay_eleg;
  logic                    tomar, acepta, retira, retorna;

  assign flanco      = peticion & ~peticion_q;
  assign elegible    = pend_q & mascara_q & {NUM_FUENTES{ge_q}};
  assign vector_calc = VECTOR_BASE + ANCHO_VECTOR'(ganador) * ANCHO_VECTOR'(VECTOR_PASO);
  assign sel_acepta  = NUM_FUENTES'(1) << idx_q;
  assign sel_ret     = NUM_FUENTES'(1) << idx_ret;

  codificador_prioridad #(.N(NUM_FUENTES), .ANCHO_IDX(ANCHO_IDX)) u_cod_elegible (
    .entrada (elegible),
    .indice  (ganador),
    .valido  (hay_eleg)
  );

`ifdef INT_ANIDADAS_EN
  logic [ANCHO_IDX-1:0] idx_serv;
  logic                 hay_serv;
  logic                 expropia;
  logic                 quedan;

  codificador_prioridad #(.N(NUM_FUENTES), .ANCHO_IDX(ANCHO_IDX)) u_cod_servicio (
    .entrada (serv_q),
    .indice  (idx_serv),
    .valido  (hay_serv)
  );

  assign expropia = hay_eleg && (!hay_serv || (ganador < idx_serv));
  assign idx_ret  = idx_serv;
  assign quedan   = |(serv_q & ~sel_ret);
`else
  assign idx_ret  = idx_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) estado_q <= REPOSO;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      REPOSO: if (hay_eleg) estado_d = SOLICITANDO;
      SOLICITANDO: begin
        if (ack) estado_d = SERVICIO;
`ifdef INT_ANIDADAS_EN
        // A withdrawn preemption falls back to the service it interrupted.
        else if (di) estado_d = (|serv_q) ? SERVICIO : REPOSO;
`else
        else if (di) estado_d = REPOSO;
`endif
      end
      SERVICIO: begin
`ifdef INT_ANIDADAS_EN
        if (reti)          estado_d = quedan ? SERVICIO : REPOSO;
        else if (expropia) estado_d = SOLICITANDO;
`else
        if (reti) estado_d = REPOSO;
`endif
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_comb begin
    irq     = 1'b0;
    tomar   = 1'b0;
    acepta  = 1'b0;
    retira  = 1'b0;
    retorna = 1'b0;
    case (estado_q)
      REPOSO: tomar = hay_eleg;
      SOLICITANDO: begin
        irq    = 1'b1;
        acepta = ack;
        retira = di & ~ack;
      end
      SERVICIO: begin
        retorna = reti;
`ifdef INT_ANIDADAS_EN
        tomar   = expropia & ~reti;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    ge_d = ge_q;
`ifndef INT_ANIDADAS_EN
    if (acepta)  ge_d = 1'b0;
    if (retorna) ge_d = 1'b1;
`endif
    if (ei) ge_d = 1'b1;
    if (di) ge_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      peticion_q <= '0;
      pend_q     <= '0;
      serv_q     <= '0;
      mascara_q  <= '0;
      ge_q       <= 1'b0;
      idx_q      <= '0;
      vector_q   <= VECTOR_BASE;
    end else begin
      peticion_q <= peticion;
      ge_q       <= ge_d;
      if (mascara_we) mascara_q <= mascara_dato;
      // A fresh edge on the source being acknowledged survives the clear.
      pend_q <= (pend_q & ~(acepta ? sel_acepta : '0)) | flanco;
      if (acepta)  serv_q <= serv_q | sel_acepta;
      if (retorna) serv_q <= serv_q & ~sel_ret;
      if (tomar) begin
        idx_q    <= ganador;
        vector_q <= vector_calc;
      end
    end
  end

  assign vector      = vector_q;
  assign pendientes  = pend_q;
  assign en_servicio = serv_q;
  assign estado_dbg  = estado_q;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Table-driven bench for controlador_interrupciones: each row is one cycle of
// inputs and the outputs expected just after the following clock edge.
module tb_controlador_interrupciones;

  typedef struct {
    logic       rst;
    logic [3:0] pet;
    logic       mwe;
    logic [3:0] mdat;
    logic       ei;
    logic       di;
    logic       ack;
    logic       reti;
    logic       irq;
    logic [9:0] vec;
    logic [3:0] pend;
    logic [3:0] serv;
    logic [1:0] est;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] peticion = '0;
  logic       mascara_we = 1'b0;
  logic [3:0] mascara_dato = '0;
  logic       ei = 1'b0;
  logic       di = 1'b0;
  logic       ack = 1'b0;
  logic       reti = 1'b0;
  logic       irq;
  logic [9:0] vector;
  logic [3:0] pendientes;
  logic [3:0] en_servicio;
  logic [1:0] estado_dbg;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tabla[$];
  vec_t cola[$];

  always #5 clk = ~clk;

  controlador_interrupciones dut (
    .clk          (clk),
    .reset        (reset),
    .peticion     (peticion),
    .mascara_we   (mascara_we),
    .mascara_dato (mascara_dato),
    .ei           (ei),
    .di           (di),
    .ack          (ack),
    .reti         (reti),
    .irq          (irq),
    .vector       (vector),
    .pendientes   (pendientes),
    .en_servicio  (en_servicio),
    .estado_dbg   (estado_dbg)
  );

  function automatic vec_t mk(logic rst, logic [3:0] pet, logic mwe, logic [3:0] mdat,
                              logic e_i, logic d_i, logic a_ck, logic r_eti,
                              logic e_irq, logic [9:0] e_vec, logic [3:0] e_pend,
                              logic [3:0] e_serv, logic [1:0] e_est);
    vec_t v;
    v.rst = rst;   v.pet = pet;   v.mwe = mwe;     v.mdat = mdat;
    v.ei = e_i;    v.di = d_i;    v.ack = a_ck;    v.reti = r_eti;
    v.irq = e_irq; v.vec = e_vec; v.pend = e_pend; v.serv = e_serv;
    v.est = e_est;
    return v;
  endfunction

  task automatic chk(input string nombre, input int fila, input logic [31:0] act,
                     input logic [31:0] esp);
    n_checks++;
    if (act !== esp) begin
      n_errors++;
      $display("FAIL row %0d %s: got %0h expected %0h", fila, nombre, act, esp);
    end
  endtask

  task automatic apply_row(input vec_t v, input int fila);
    reset        = v.rst;
    peticion     = v.pet;
    mascara_we   = v.mwe;
    mascara_dato = v.mdat;
    ei           = v.ei;
    di           = v.di;
    ack          = v.ack;
    reti         = v.reti;
    @(posedge clk);
    #1;
    chk("irq",         fila, 32'(irq),         32'(v.irq));
    chk("vector",      fila, 32'(vector),      32'(v.vec));
    chk("pendientes",  fila, 32'(pendientes),  32'(v.pend));
    chk("en_servicio", fila, 32'(en_servicio), 32'(v.serv));
    chk("estado",      fila, 32'(estado_dbg),  32'(v.est));
  endtask

  initial begin
    //                 rst pet     mwe mdat    ei di ak rt  irq vec     pend    serv    est
    // reset, unmask all, enable
    tabla.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3C0, 4'b0000, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 1, 4'b1111, 1, 0, 0, 0,  0, 10'h3C0, 4'b0000, 4'b0000, 2'd0));
    // single source 2: two-cycle latency, ack, reti
    tabla.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3C0, 4'b0100, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3C8, 4'b0100, 4'b0000, 2'd1));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,  0, 10'h3C8, 4'b0000, 4'b0100, 2'd2));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0, 10'h3C8, 4'b0000, 4'b0000, 2'd0));
    // simultaneous edges on 3 and 1: 1 first, 3 after reti
    tabla.push_back(mk(0, 4'b1010, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3C8, 4'b1010, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3C4, 4'b1010, 4'b0000, 2'd1));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,  0, 10'h3C4, 4'b1000, 4'b0010, 2'd2));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3C4, 4'b1000, 4'b0010, 2'd2));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0, 10'h3C4, 4'b1000, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3CC, 4'b1000, 4'b0000, 2'd1));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,  0, 10'h3CC, 4'b0000, 4'b1000, 2'd2));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0, 10'h3CC, 4'b0000, 4'b0000, 2'd0));
    // masked source 0 latches, fires once unmasked
    tabla.push_back(mk(0, 4'b0000, 1, 4'b1110, 0, 0, 0, 0,  0, 10'h3CC, 4'b0000, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3CC, 4'b0001, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3CC, 4'b0001, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3CC, 4'b0001, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 1, 4'b1111, 0, 0, 0, 0,  0, 10'h3CC, 4'b0001, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3C0, 4'b0001, 4'b0000, 2'd1));
    // di withdraws irq, pending kept; ei re-arms
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 0, 0,  0, 10'h3C0, 4'b0001, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3C0, 4'b0001, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0,  0, 10'h3C0, 4'b0001, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3C0, 4'b0001, 4'b0000, 2'd1));
    // ack beats di; stray ack in SERVICIO and stray reti in REPOSO ignored
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1, 1, 0,  0, 10'h3C0, 4'b0000, 4'b0001, 2'd2));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,  0, 10'h3C0, 4'b0000, 4'b0001, 2'd2));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 1,  0, 10'h3C0, 4'b0000, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0, 10'h3C0, 4'b0000, 4'b0000, 2'd0));
    // reset in the middle of a service, then an ignored reti
    tabla.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3C0, 4'b0010, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3C4, 4'b0010, 4'b0000, 2'd1));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,  0, 10'h3C4, 4'b0000, 4'b0010, 2'd2));
    tabla.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3C0, 4'b0000, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0, 10'h3C0, 4'b0000, 4'b0000, 2'd0));
    // mask came back cleared: edge latches but stays quiet until unmasked
    tabla.push_back(mk(0, 4'b0100, 0, 4'b0000, 1, 0, 0, 0,  0, 10'h3C0, 4'b0100, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3C0, 4'b0100, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 1, 4'b1111, 0, 0, 0, 0,  0, 10'h3C0, 4'b0100, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3C8, 4'b0100, 4'b0000, 2'd1));
    // new edge on the acknowledged source: set wins over clear
    tabla.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 0, 1, 0,  0, 10'h3C8, 4'b0100, 4'b0100, 2'd2));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0, 10'h3C8, 4'b0100, 4'b0000, 2'd0));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3C8, 4'b0100, 4'b0000, 2'd1));
    // higher-priority edge while requesting: winner and vector stay frozen
    tabla.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3C8, 4'b0101, 4'b0000, 2'd1));
    tabla.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,  0, 10'h3C8, 4'b0001, 4'b0100, 2'd2));

    for (int i = 0; i < tabla.size(); i++) apply_row(tabla[i], i);

`ifdef INT_ANIDADAS_EN
    // source 0 preempts source 2; reti unwinds one level at a time
    cola.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3C0, 4'b0001, 4'b0100, 2'd1));
    cola.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,  0, 10'h3C0, 4'b0000, 4'b0101, 2'd2));
    cola.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0, 10'h3C0, 4'b0000, 4'b0100, 2'd2));
    cola.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0, 10'h3C0, 4'b0000, 4'b0000, 2'd0));
`else
    // single level: pending source 0 waits for reti, then one idle cycle
    cola.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 10'h3C8, 4'b0001, 4'b0100, 2'd2));
    cola.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0, 10'h3C8, 4'b0001, 4'b0000, 2'd0));
    cola.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 10'h3C0, 4'b0001, 4'b0000, 2'd1));
    cola.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0,  0, 10'h3C0, 4'b0000, 4'b0001, 2'd2));
`endif
    for (int i = 0; i < cola.size(); i++) apply_row(cola[i], 100 + i);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
